// File: rtl/noc_axi4_bridge_wr_sched_if.sv
// Bus bundle between the NoC requesters, the write scheduler and the write engine.
// The master modport is the scheduler's view; the slave modport is the surrounding logic.
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 3
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 8
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif
`ifndef AXI4_STRB_WIDTH
`define AXI4_STRB_WIDTH 4
`endif

interface noc_axi4_bridge_wr_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]                        in_val;
  logic [NUM_REQ*`AXI4_ADDR_WIDTH-1:0]       in_addr;
  logic [NUM_REQ*`MSG_DATA_SIZE_WIDTH-1:0]   in_size_log;
  logic [NUM_REQ*`AXI4_ID_WIDTH-1:0]         in_id;
  logic [NUM_REQ*`AXI4_DATA_WIDTH-1:0]       in_data;
  logic [NUM_REQ*`AXI4_STRB_WIDTH-1:0]       in_strb;
  logic [NUM_REQ-1:0]                        in_rdy;
  logic [NUM_REQ-1:0]                        out_resp_val;
  logic [`AXI4_ID_WIDTH-1:0]                 out_resp_id;
  logic [NUM_REQ-1:0]                        out_resp_rdy;
  logic                                      req_val;
  logic [`AXI4_ADDR_WIDTH-1:0]               req_addr;
  logic [`MSG_DATA_SIZE_WIDTH-1:0]           req_size_log;
  logic [`AXI4_ID_WIDTH-1:0]                 req_id;
  logic [`AXI4_DATA_WIDTH-1:0]               req_data;
  logic [`AXI4_STRB_WIDTH-1:0]               req_strb;
  logic                                      req_rdy;
  logic                                      resp_val;
  logic [`AXI4_ID_WIDTH-1:0]                 resp_id;
  logic                                      resp_rdy;

  modport master (
    input  in_val, in_addr, in_size_log, in_id, in_data, in_strb, out_resp_rdy,
           req_rdy, resp_val, resp_id,
    output in_rdy, out_resp_val, out_resp_id, req_val, req_addr, req_size_log,
           req_id, req_data, req_strb, resp_rdy
  );

  modport slave (
    output in_val, in_addr, in_size_log, in_id, in_data, in_strb, out_resp_rdy,
           req_rdy, resp_val, resp_id,
    input  in_rdy, out_resp_val, out_resp_id, req_val, req_addr, req_size_log,
           req_id, req_data, req_strb, resp_rdy
  );
endinterface

// File: rtl/noc_axi4_bridge_wr_sched.sv
// Round-robin write scheduler: accept-to-req_val 1 cycle, in_rdy low while issuing or out of credit, B routing combinational.
// Watchdog (sticky timeout_err) is built only with NOC_AXI4_BRIDGE_WR_SCHED_TIMEOUT_EN defined.
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 3
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 8
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif
`ifndef AXI4_STRB_WIDTH
`define AXI4_STRB_WIDTH 4
`endif

module noc_axi4_bridge_wr_sched #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic                       clk,
  input  logic                       rst_n,
  noc_axi4_bridge_wr_sched_if.master bus,
  output logic [7:0]                 outstanding,
  output logic                       timeout_err
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int AW    = `AXI4_ADDR_WIDTH;
  localparam int SW    = `MSG_DATA_SIZE_WIDTH;
  localparam int IW    = `AXI4_ID_WIDTH;
  localparam int DW    = `AXI4_DATA_WIDTH;
  localparam int BW    = `AXI4_STRB_WIDTH;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win;
  logic [IDX_W:0]   cand;
  logic             found;
  logic             credit;
  logic             accept;
  logic [IDX_W-1:0] k;
  logic             k_valid;
  logic             resp_hs;
  logic             dec;

  assign credit = (outstanding < 8'(MAX_OUTSTANDING));

  // Scan from rr_ptr upward, wrapping, so the last winner has lowest priority.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!found && bus.in_val[cand[IDX_W-1:0]]) begin
        win   = cand[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

  assign accept = (state == S_IDLE) && credit && found;

  always_comb begin
    bus.in_rdy = '0;
    if (accept) bus.in_rdy[win] = 1'b1;
  end

  assign bus.req_val = (state == S_ISSUE);

  // Low ID bits carry the requester index; indices past NUM_REQ are sunk so the credit still returns.
  assign k       = bus.resp_id[IDX_W-1:0];
  assign k_valid = (int'(k) < NUM_REQ);

  always_comb begin
    bus.out_resp_val = '0;
    bus.resp_rdy     = 1'b1;
    if (k_valid) begin
      bus.out_resp_val[k] = bus.resp_val;
      bus.resp_rdy        = bus.out_resp_rdy[k];
    end
  end

  assign bus.out_resp_id = bus.resp_id >> IDX_W;
  assign resp_hs         = bus.resp_val & bus.resp_rdy;
  assign dec             = resp_hs && (outstanding != 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      rr_ptr           <= '0;
      outstanding      <= '0;
      bus.req_addr     <= '0;
      bus.req_size_log <= '0;
      bus.req_id       <= '0;
      bus.req_data     <= '0;
      bus.req_strb     <= '0;
    end else begin
      if (accept) begin
        state            <= S_ISSUE;
        rr_ptr           <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
        bus.req_addr     <= bus.in_addr[win*AW +: AW];
        bus.req_size_log <= bus.in_size_log[win*SW +: SW];
        bus.req_id       <= {bus.in_id[win*IW +: (IW-IDX_W)], win};
        bus.req_data     <= bus.in_data[win*DW +: DW];
        bus.req_strb     <= bus.in_strb[win*BW +: BW];
      end else if (state == S_ISSUE && bus.req_rdy) begin
        state <= S_IDLE;
      end
      if (accept && !dec) begin
        outstanding <= outstanding + 8'd1;
      end else if (!accept && dec) begin
        outstanding <= outstanding - 8'd1;
      end
    end
  end

`ifdef NOC_AXI4_BRIDGE_WR_SCHED_TIMEOUT_EN
  logic [15:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (resp_hs || outstanding == 8'd0) begin
        wd_cnt <= '0;
      end else if (wd_cnt != 16'hFFFF) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
      if (outstanding != 8'd0 && wd_cnt == 16'(TIMEOUT_CYCLES)) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_axi4_bridge_wr_sched.sv
// Scoreboard bench for noc_axi4_bridge_wr_sched: NUM_REQ=4, MAX_OUTSTANDING=2, TIMEOUT_CYCLES=20.
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 3
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 8
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif
`ifndef AXI4_STRB_WIDTH
`define AXI4_STRB_WIDTH 4
`endif

module tb_noc_axi4_bridge_wr_sched;
  localparam int NUM_REQ = 4;
  localparam int MAX_OUT = 2;
  localparam int AW = `AXI4_ADDR_WIDTH;
  localparam int SW = `MSG_DATA_SIZE_WIDTH;
  localparam int IW = `AXI4_ID_WIDTH;
  localparam int DW = `AXI4_DATA_WIDTH;
  localparam int BW = `AXI4_STRB_WIDTH;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [SW-1:0] size;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [BW-1:0] strb;
  } pkt_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] outstanding;
  logic       timeout_err;

  noc_axi4_bridge_wr_sched_if #(.NUM_REQ(NUM_REQ)) bus();

  noc_axi4_bridge_wr_sched #(
    .NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAX_OUT), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .outstanding(outstanding), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model and scoreboard, sampled on the falling edge.
  pkt_t exp_q[$];
  int   grant_log[$];
  int   m_ptr, m_out, m_win, k;
  bit   m_issue, m_acc, m_dec, old_issue;
  bit   req_hs_now, resp_hs_now;
  logic [IW-1:0] req_hs_id;
  logic [IW-1:0] tid;
  logic [NUM_REQ-1:0] exp_rdy;
  pkt_t p, q;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_issue = 0; m_ptr = 0; m_out = 0;
      req_hs_now = 0; resp_hs_now = 0;
      exp_q.delete();
    end else begin
      exp_rdy = '0; m_acc = 0; m_win = 0;
      if (!m_issue && m_out < MAX_OUT) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!m_acc && bus.in_val[(m_ptr + i) % NUM_REQ]) begin
            m_win = (m_ptr + i) % NUM_REQ;
            m_acc = 1;
            exp_rdy[m_win] = 1'b1;
          end
        end
      end
      chk("in_rdy", 64'(bus.in_rdy), 64'(exp_rdy));
      chk("outstanding", 64'(outstanding), 64'(m_out));
      chk("req_val", 64'(bus.req_val), 64'(m_issue));
      old_issue = m_issue;
      req_hs_now = 0;
      if (old_issue && bus.req_rdy) begin
        req_hs_now = 1;
        req_hs_id  = bus.req_id;
        chk("sb_depth", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          q = exp_q.pop_front();
          chk("sb_addr", 64'(bus.req_addr), 64'(q.addr));
          chk("sb_size", 64'(bus.req_size_log), 64'(q.size));
          chk("sb_id", 64'(bus.req_id), 64'(q.id));
          chk("sb_data", 64'(bus.req_data), 64'(q.data));
          chk("sb_strb", 64'(bus.req_strb), 64'(q.strb));
        end
        m_issue = 0;
      end
      if (m_acc) begin
        tid    = bus.in_id[m_win*IW +: IW];
        p.addr = bus.in_addr[m_win*AW +: AW];
        p.size = bus.in_size_log[m_win*SW +: SW];
        p.id   = {tid[IW-3:0], 2'(m_win)};
        p.data = bus.in_data[m_win*DW +: DW];
        p.strb = bus.in_strb[m_win*BW +: BW];
        exp_q.push_back(p);
        grant_log.push_back(m_win);
        m_issue = 1;
        m_ptr = (m_win + 1) % NUM_REQ;
      end
      m_dec = 0;
      if (bus.resp_val) begin
        k = int'(bus.resp_id[1:0]);
        chk("resp_rdy", 64'(bus.resp_rdy), 64'(bus.out_resp_rdy[k]));
        chk("out_resp_val", 64'(bus.out_resp_val), 64'd1 << k);
        chk("out_resp_id", 64'(bus.out_resp_id), 64'(bus.resp_id >> 2));
        m_dec = bus.out_resp_rdy[k] && (m_out > 0);
      end else begin
        chk("out_resp_val_idle", 64'(bus.out_resp_val), 64'd0);
      end
      resp_hs_now = bus.resp_val && bus.resp_rdy;
      m_out = m_out + int'(m_acc) - int'(m_dec);
    end
  end

  bit auto_resp;
  logic [IW-1:0] pend[$];

  // One cycle; the auto responder answers each issued write the cycle after its handshake.
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_resp) begin
      if (req_hs_now) pend.push_back(req_hs_id);
      if (bus.resp_val && resp_hs_now) bus.resp_val = 1'b0;
      if (!bus.resp_val && pend.size() > 0) begin
        bus.resp_id  = pend.pop_front();
        bus.resp_val = 1'b1;
      end
    end
  endtask

  task automatic load_fields(input logic [7:0] seed);
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.in_addr[i*AW +: AW]     = AW'({seed, 16'hA000, 8'(i * 8)});
      bus.in_size_log[i*SW +: SW] = SW'(i + 1);
      bus.in_id[i*IW +: IW]       = IW'(seed) + IW'(i);
      bus.in_data[i*DW +: DW]     = DW'({8'(i), seed, 16'hC0DE});
      bus.in_strb[i*BW +: BW]     = BW'(seed) ^ BW'(i);
    end
  endtask

  task automatic drain();
    auto_resp = 0;
    pend.delete();
    bus.in_val = '0;
    bus.req_rdy = 1'b1;
    bus.out_resp_rdy = '1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (outstanding == 8'd0 && !bus.req_val) break;
      bus.resp_val = (outstanding != 8'd0);
      bus.resp_id  = '0;
    end
    bus.resp_val = 1'b0;
    chk("drain", 64'(outstanding), 64'd0);
  endtask

  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [IW-1:0] e_id;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0; auto_resp = 0;
    rst_n = 1'b0;
    bus.in_val = '0; bus.out_resp_rdy = '1; bus.req_rdy = 1'b0;
    bus.resp_val = 1'b0; bus.resp_id = '0;
    load_fields(8'h11);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy", 64'(bus.in_rdy), 64'd0);
    chk("rst_req_val", 64'(bus.req_val), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_req_addr", 64'(bus.req_addr), 64'd0);
    chk("rst_req_id", 64'(bus.req_id), 64'd0);
    chk("rst_req_data", 64'(bus.req_data), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Fairness: all requesters valid, engine always ready, responses immediate.
    auto_resp = 1; bus.req_rdy = 1'b1; bus.in_val = '1;
    for (int c = 0; c < 60 && grant_log.size() < 5; c++) step();
    bus.in_val = '0;
    chk("fair_grants", 64'(grant_log.size() >= 5), 64'd1);
    if (grant_log.size() >= 5)
      for (int g = 0; g < 5; g++) chk("fair_order", 64'(grant_log[g]), 64'(g % 4));
    drain();

    // ID tagging and response routing.
    load_fields(8'h22);
    bus.in_id[2*IW +: IW] = 8'd5;
    bus.req_rdy = 1'b0; bus.in_val = 4'b0100;
    step();
    bus.in_val = '0;
    #1;
    chk("id_tag_val", 64'(bus.req_val), 64'd1);
    chk("id_tag", 64'(bus.req_id), 64'd22);
    bus.req_rdy = 1'b1;
    step();
    bus.resp_val = 1'b1; bus.resp_id = 8'd22;
    #1;
    chk("route_val", 64'(bus.out_resp_val), 64'b0100);
    chk("route_id", 64'(bus.out_resp_id), 64'd5);
    chk("route_rdy", 64'(bus.resp_rdy), 64'd1);
    step();
    bus.resp_val = 1'b0;
    #1 chk("route_credit", 64'(outstanding), 64'd0);
    drain();

    // Credit exhaustion and recovery.
    load_fields(8'h5A);
    bus.req_rdy = 1'b1; bus.in_val = '1;
    repeat (8) step();
    #1;
    chk("credit_full_out", 64'(outstanding), 64'd2);
    chk("credit_full_rdy", 64'(bus.in_rdy), 64'd0);
    bus.resp_val = 1'b1; bus.resp_id = 8'h01;
    step();
    #1 chk("credit_back_rdy", 64'(bus.in_rdy != '0), 64'd1);
    step();
    bus.resp_val = 1'b0;
    #1;
    chk("credit_simul_out", 64'(outstanding), 64'd1);
    chk("credit_simul_val", 64'(bus.req_val), 64'd1);
    step();
    step();
    #1 chk("credit_refill", 64'(outstanding), 64'd2);
    drain();

    // Engine backpressure: held fields stay stable.
    load_fields(8'h33);
    bus.req_rdy = 1'b0; bus.in_val = 4'b0010;
    e_addr = bus.in_addr[AW +: AW];
    e_data = bus.in_data[DW +: DW];
    tid    = bus.in_id[IW +: IW];
    e_id   = {tid[IW-3:0], 2'd1};
    step();
    bus.in_val = '1;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp_val", 64'(bus.req_val), 64'd1);
      chk("bp_addr", 64'(bus.req_addr), 64'(e_addr));
      chk("bp_data", 64'(bus.req_data), 64'(e_data));
      chk("bp_id", 64'(bus.req_id), 64'(e_id));
      chk("bp_in_rdy", 64'(bus.in_rdy), 64'd0);
      step();
    end
    bus.req_rdy = 1'b1;
    step();
    #1 chk("bp_release", 64'(bus.req_val), 64'd0);
    bus.in_val = '0;
    drain();

    // Response stall on requester 1.
    load_fields(8'h44);
    bus.in_id[IW +: IW] = 8'd3;
    bus.in_val = 4'b0010; bus.req_rdy = 1'b1;
    step();
    bus.in_val = '0;
    step();
    bus.out_resp_rdy = 4'b1101; bus.resp_val = 1'b1; bus.resp_id = 8'd13;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_rdy", 64'(bus.resp_rdy), 64'd0);
      chk("stall_out", 64'(outstanding), 64'd1);
      chk("stall_vld", 64'(bus.out_resp_val), 64'b0010);
      step();
    end
    bus.out_resp_rdy = '1;
    #1 chk("stall_go", 64'(bus.resp_rdy), 64'd1);
    step();
    bus.resp_val = 1'b0;
    #1 chk("stall_done", 64'(outstanding), 64'd0);
    drain();

    // Watchdog: one write never answered.
    bus.in_val = 4'b0001; bus.req_rdy = 1'b1;
    step();
    bus.in_val = '0;
    repeat (10) step();
    #1 chk("wd_early", 64'(timeout_err), 64'd0);
    repeat (15) step();
    #1;
`ifdef NOC_AXI4_BRIDGE_WR_SCHED_TIMEOUT_EN
    chk("wd_fire", 64'(timeout_err), 64'd1);
`else
    chk("wd_off", 64'(timeout_err), 64'd0);
`endif

    // Reset while a request is held in ISSUE.
    bus.req_rdy = 1'b0; bus.in_val = 4'b0010;
    step();
    bus.in_val = '0;
    #1 chk("rst_pre_val", 64'(bus.req_val), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_val", 64'(bus.req_val), 64'd0);
    chk("rst_mid_out", 64'(outstanding), 64'd0);
    chk("rst_mid_timeout", 64'(timeout_err), 64'd0);
    step();
    step();
    #1 rst_n = 1'b1;
    bus.in_val = 4'b1000; bus.req_rdy = 1'b1;
    step();
    bus.in_val = '0;
    step();
    #1 chk("post_rst_out", 64'(outstanding), 64'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
